// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU among NREQ requesters.
// It takes one operation per cycle over a valid/ready request channel, drives the winner's
// operands onto the ALU, captures result/zero in a register and holds them until the owning
// requester takes them over its valid/ready response channel.
//
// Ports:
//   clk, reset                  clock (rising edge) and asynchronous active-high reset
//   req_valid/req_ready         per-requester request handshake (at most one ready bit set)
//   req_op1/req_op2/req_alu_op  packed per-requester operands, requester i at slot i
//   rsp_valid/rsp_ready         per-requester response handshake (at most one valid bit set)
//   rsp_result/rsp_zero         registered ALU outputs, qualified by rsp_valid
//   alu_op1/alu_op2/alu_alu_op  drive the shared ALU inputs
//   alu_result/alu_zero         shared ALU outputs
module alu_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_op1,
  input  logic [NREQ*32-1:0] req_op2,
  input  logic [NREQ*4-1:0] req_alu_op,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [31:0]       rsp_result,
  output logic              rsp_zero,
  output logic [31:0]       alu_op1,
  output logic [31:0]       alu_op2,
  output logic [3:0]        alu_alu_op,
  input  logic [31:0]       alu_result,
  input  logic              alu_zero
);

  localparam int unsigned IdxW = $clog2(NREQ);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e          r_state, w_state_d;
  logic [IdxW-1:0] r_ptr, r_owner;
  logic [IdxW-1:0] w_gnt_idx, w_cand, w_sel;
  logic            w_gnt_found, w_can_accept, w_accept;

  // A new operation may enter when nothing is held or the held response leaves this cycle.
  assign w_can_accept = (r_state == StIdle) || ((r_state == StResp) && rsp_ready[r_owner]);

  // Round-robin search starting just after the last granted index.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = IdxW'((32'(r_ptr) + k) % NREQ);
      if (!w_gnt_found && req_valid[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
  end

  // Accepts are blocked while reset is high so nothing is captured across reset.
  assign w_accept = w_can_accept && w_gnt_found && !reset;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_gnt_idx] = 1'b1;
  end

  // Operand mux falls back to requester 0 so the ALU never sees X.
  assign w_sel = w_accept ? w_gnt_idx : '0;

  always_comb begin
    alu_op1    = req_op1[31:0];
    alu_op2    = req_op2[31:0];
    alu_alu_op = req_alu_op[3:0];
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_sel == IdxW'(i)) begin
        alu_op1    = req_op1[32*i +: 32];
        alu_op2    = req_op2[32*i +: 32];
        alu_alu_op = req_alu_op[4*i +: 4];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (r_state == StResp) rsp_valid[r_owner] = 1'b1;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: if (w_accept) w_state_d = StResp;
      StResp: begin
        if (w_accept) begin
          w_state_d = StResp;
        end else if (rsp_ready[r_owner]) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_ptr      <= IdxW'(NREQ - 1);
      r_owner    <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        r_owner    <= w_gnt_idx;
        r_ptr      <= w_gnt_idx;
      end
    end
  end

endmodule
